// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-side types and constants.
package rv32i_pkg;

  typedef enum logic [1:0] {
    StBoot    = 2'd0,
    StFetch   = 2'd1,
    StDeliver = 2'd2,
    StHalt    = 2'd3
  } seq_state_t;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority mux for the next PC: boot > trap > redirect > sequential advance > hold.
module pc_next_mux
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  seq_state_t  state,
  input  logic [31:0] pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_req,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc    = pc;
    misaligned = 1'b0;
    if (state == StBoot) begin
      next_pc = RESET_VECTOR;
    end else if (trap_req) begin
      next_pc = TRAP_VECTOR;
    end else if (redirect_valid) begin
      if (is_misaligned(redirect_target)) begin
        next_pc    = TRAP_VECTOR;
        misaligned = 1'b1;
      end else begin
        next_pc = redirect_target;
      end
    end else if (state == StDeliver && instr_ready) begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives next_pc, runs the imem handshake and hands instructions to decode.
module pc_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter logic [31:0] NOP_INSTR    = RV_NOP
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_req,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_misaligned,
  output logic [31:0] bad_addr
);

  seq_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        misaligned;
  logic        flush;

  pc_next_mux #(
    .RESET_VECTOR (RESET_VECTOR),
    .TRAP_VECTOR  (TRAP_VECTOR)
  ) u_next_mux (
    .state           (state_q),
    .pc              (pc),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .next_pc         (next_pc),
    .misaligned      (misaligned)
  );

  assign flush = (state_q != StBoot) && (trap_req || redirect_valid);

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    bad_addr_d = bad_addr_q;
    case (state_q)
      StBoot:    state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          state_d = StDeliver;
          instr_d = imem_rdata;
        end
      end
      StDeliver: if (instr_ready) state_d = halt ? StHalt : StFetch;
      StHalt:    if (!halt) state_d = StFetch;
      default:   state_d = StBoot;
    endcase
    // Trap/redirect override the state action and discard any same-cycle ack data.
    if (flush) begin
      state_d = StFetch;
      instr_d = instr_q;
    end
    if (misaligned) bad_addr_d = redirect_target;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= StBoot;
      instr_q    <= NOP_INSTR;
      bad_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  assign imem_req         = (state_q == StFetch);
  assign imem_addr        = pc;
  assign instr            = instr_q;
  assign instr_pc         = pc;
  assign instr_valid      = (state_q == StDeliver);
  assign halted           = (state_q == StHalt);
  assign fetch_misaligned = misaligned;
  assign bad_addr         = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer against a flag-based reference model of the fetch loop.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic        halt;
  logic        halted;
  logic        fetch_misaligned;
  logic [31:0] bad_addr;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .NOP_INSTR    (NOP)
  ) dut (
    .clk              (clk),
    .clr              (clr),
    .pc               (pc),
    .next_pc          (next_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .trap_req         (trap_req),
    .halt             (halt),
    .halted           (halted),
    .fetch_misaligned (fetch_misaligned),
    .bad_addr         (bad_addr)
  );

  always #5 clk = ~clk;

  // Stand-in for the program_counter register: loads next_pc every clock.
  always @(posedge clk) pc <= next_pc;

  typedef struct {
    logic [31:0] next_pc;
    logic        valid;
    logic        req;
    logic        halted;
    logic        mis;
    logic [31:0] instr;
    logic [31:0] bad;
    logic [31:0] addr;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: booting / holding an instruction / parked; fetching otherwise.
  bit          m_boot, m_hold, m_park;
  logic [31:0] m_instr, m_bad;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot  = 1'b1;
    m_hold  = 1'b0;
    m_park  = 1'b0;
    m_instr = NOP;
    m_bad   = 32'h0;
  endtask

  task automatic cycle(input logic ack, input logic rdy, input logic rv,
                       input logic [31:0] tgt, input logic tr, input logic hl);
    exp_t e;
    logic fetching, mis;
    @(negedge clk);
    imem_ack        = ack;
    imem_rdata      = $urandom;
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    trap_req        = tr;
    halt            = hl;
    #1;
    fetching = !m_boot && !m_hold && !m_park;
    mis      = !m_boot && rv && !tr && (tgt % 4 != 0);
    e.valid  = m_hold;
    e.req    = fetching;
    e.halted = m_park;
    e.mis    = mis;
    e.instr  = m_instr;
    e.bad    = m_bad;
    e.addr   = pc;
    if (m_boot)              e.next_pc = RV;
    else if (tr || mis)      e.next_pc = TV;
    else if (rv)             e.next_pc = tgt;
    else if (m_hold && rdy)  e.next_pc = pc + 32'd4;
    else                     e.next_pc = pc;
    sb_q.push_back(e);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (tr || rv) begin
      m_hold = 1'b0;
      m_park = 1'b0;
      if (mis) m_bad = tgt;
    end else if (fetching && ack) begin
      m_hold  = 1'b1;
      m_instr = imem_rdata;
    end else if (m_hold && rdy) begin
      m_hold = 1'b0;
      m_park = hl;
    end else if (m_park && !hl) begin
      m_park = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = $urandom & 32'hFFFF_FFFC;
      1:       t = $urandom;
      2:       t = 32'hFFFF_FFFC;
      default: t = {22'h0, $urandom_range(0, 255) & 8'hFF, 2'b00};
    endcase
    return t;
  endfunction

  // Monitor: pops one expected response per cycle, after the stimulus has settled.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("next_pc", next_pc, e.next_pc);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, e.valid});
        chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
        chk("halted", {31'h0, halted}, {31'h0, e.halted});
        chk("fetch_misaligned", {31'h0, fetch_misaligned}, {31'h0, e.mis});
        chk("instr", instr, e.instr);
        chk("bad_addr", bad_addr, e.bad);
        chk("imem_addr", imem_addr, e.addr);
        chk("instr_pc", instr_pc, e.addr);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] pc_seq [5];
    pc_seq = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
    clr = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0; trap_req = 1'b0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_next_pc", next_pc, RV);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_bad_addr", bad_addr, 32'h0);
    @(posedge clk);
    #1 clr = 1'b1;

    // Free-running fetch: one instruction every two cycles.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("pc_seq", pc, pc_seq[i]);
    end

    // Redirect while delivering with ready high drops the instruction.
    cycle(1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("redir_pc", pc, 32'h40);
    // Misaligned redirect, then trap+redirect against a same-cycle ack.
    cycle(1'b0, 1'b0, 1'b1, 32'h42, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("trap_pc", pc, TV);
    // Wrap at the top of the address space, then park on halt.
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc", pc, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) == 0), rand_target(),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0));
    end

    // Asynchronous reset while an instruction is held, with ack still asserted.
    for (int i = 0; i < 4 && !m_hold; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2 clr = 1'b0;
    #1;
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    chk("arst_instr", instr, NOP);
    chk("arst_next_pc", next_pc, RV);
    chk("arst_halted", {31'h0, halted}, 32'h0);
    @(posedge clk);
    #1 clr = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    #3;
    chk("sb_drained", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that drives `next_pc` into the `program_counter` register and sequences instruction-memory fetches for the RV32I core.
- Arbitrates between sequential advance, branch/jump redirect, trap entry and halt.
- Owns the imem request/ack handshake and the valid/ready handoff to decode.
- The PC register updates every clock, so this block must drive `next_pc` = `pc` whenever the PC is to hold.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset release.
- TRAP_VECTOR, 32'h0000_0100, target on trap entry or misaligned redirect.
- NOP_INSTR, 32'h0000_0013, value of `instr` at reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-low.
- pc  in  32  current PC from the `program_counter` register.
- next_pc  out  32  next PC value, combinational.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals `pc`.
- imem_ack  in  1  fetch accepted; `imem_rdata` is valid in the same cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  registered instruction to decode.
- instr_pc  out  32  PC of `instr`; equals `pc` while in DELIVER.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts the instruction.
- redirect_valid  in  1  taken branch/jump from execute.
- redirect_target  in  32  branch/jump target.
- trap_req  in  1  trap request (ecall/illegal, etc.).
- halt  in  1  halt request (ebreak/debug).
- halted  out  1  high in HALT.
- fetch_misaligned  out  1  one-cycle pulse when a misaligned redirect is trapped.
- bad_addr  out  32  registered; last misaligned target.

Behaviour:
- Reset (`clr` low, async): state=BOOT, `instr`=NOP_INSTR, `bad_addr`=0. Outputs while held in reset:
  - `instr_valid`=0, `imem_req`=0, `halted`=0, `fetch_misaligned`=0.
  - `next_pc`=RESET_VECTOR.
- States: BOOT, FETCH, DELIVER, HALT. Encoding is binary, 2 bits.
- Priority in every non-BOOT state: trap_req > redirect_valid > state action. Trap and redirect are evaluated in all of FETCH, DELIVER and HALT.
- BOOT:
  - `next_pc`=RESET_VECTOR; → FETCH on the first clock after `clr` rises.
  - `trap_req`, `redirect_valid` and `halt` are ignored.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`, `next_pc`=`pc`.
  - On `imem_ack`: `instr`<=`imem_rdata`, → DELIVER.
  - The address may change before acceptance; no request is outstanding across cycles.
- DELIVER:
  - `instr_valid`=1, `imem_req`=0.
  - On `instr_ready`: `next_pc`=`pc`+4, then → HALT if `halt`, else → FETCH.
  - Without `instr_ready`: `next_pc`=`pc`, hold.
- HALT:
  - `halted`=1, `imem_req`=0, `next_pc`=`pc`.
  - → FETCH when `halt`=0.
- Redirect (aligned, `redirect_target[1:0]`==0):
  - `next_pc`=`redirect_target`, → FETCH.
  - In DELIVER the held instruction is dropped (`instr_valid` low next cycle), even if `instr_ready`=1 in the same cycle.
  - In FETCH a same-cycle `imem_ack` is discarded and `instr` is not updated.
- Misaligned redirect (`redirect_target[1:0]`!=0):
  - `next_pc`=TRAP_VECTOR, `fetch_misaligned`=1 for that cycle, `bad_addr`<=`redirect_target`, → FETCH.
- Trap: `next_pc`=TRAP_VECTOR, → FETCH. Any held instruction or same-cycle ack is discarded, exactly as for redirect.
- `halt` in FETCH or DELIVER is acted on only after the current instruction is handed off. In HALT, redirect and trap still apply and exit HALT to FETCH.
- Arithmetic: `pc`+4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- Latency:
  - Best case, an instruction issues every 2 cycles (FETCH with immediate ack, then DELIVER with ready).
  - Redirect to first fetch of the target: 1 cycle.
- Reset mid-operation: immediate return to BOOT values; a pending ack is ignored.

Decomposition:
- Shared package `rv32i_pkg`:
  - state enum `seq_state_t`.
  - constants `RV_NOP`=32'h13 and `PC_STEP`=4.
  - ALIGN_MASK=2'b11.
- Natural sub-module `pc_next_mux`: the combinational priority mux producing `next_pc` and the misaligned flag.
- The FSM stays in `pc_sequencer`.

Test Plan:
- Release `clr`, `imem_ack` always 1, `instr_ready` always 1 → `pc` sequence 0,0,4,4,8; `instr_valid` alternates 0/1, starting in cycle 2.
- In DELIVER at `pc`=0x10, assert `redirect_valid` with target 0x40 and `instr_ready`=1 → no handoff; next `pc`=0x40; `imem_addr`=0x40 one cycle later.
- Redirect to 0x42 → `fetch_misaligned` pulses once, `bad_addr`=0x42, `pc`=0x100.
- Assert `trap_req` and `redirect_valid` (target 0x80) together in FETCH with `imem_ack`=1 → `pc`=0x100, ack data discarded, `instr` unchanged.
- `pc`=0xFFFF_FFFC, deliver with ready → `pc` wraps to 0x0. With `halt`=1 at handoff → `halted`=1 and `pc` holds until `halt`=0.
- Assert `clr`=0 mid-DELIVER → `instr_valid` and `imem_req` go 0 asynchronously and `instr`=0x13. After release, fetch restarts at RESET_VECTOR.
